// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the registered multi-cycle ALU.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLT  = 4'b0101,
    OP_SLTU = 4'b0110,
    OP_SLL  = 4'b0111,
    OP_SRL  = 4'b1000,
    OP_SRA  = 4'b1001,
    OP_MUL  = 4'b1010,
    OP_DIVU = 4'b1011,
    OP_REMU = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic is_iterative(input logic [OP_W-1:0] code);
    return code inside {OP_MUL, OP_DIVU, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: shift-add multiply and restoring unsigned divide, one step per cycle.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  // mcand holds multiplicand (MUL) or divisor (DIV); mplier holds multiplier or dividend/quotient.
  logic [OP_W-1:0]    op_q;
  logic [WIDTH-1:0]   acc, acc_nxt;
  logic [WIDTH-1:0]   mcand, mcand_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH:0]     rem_sh, trial;

  always_comb begin
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    rem_sh     = '0;
    trial      = '0;
    if (op_q == OP_MUL) begin
      if (mplier[0]) acc_nxt = acc + mcand;
      mcand_nxt  = mcand << 1;
      mplier_nxt = mplier >> 1;
    end else begin
      // Partial remainder stays below the divisor, so a non-negative trial fits WIDTH bits.
      rem_sh = {acc, mplier[WIDTH-1]};
      trial  = rem_sh - {1'b0, mcand};
      if (!trial[WIDTH]) begin
        acc_nxt    = trial[WIDTH-1:0];
        mplier_nxt = {mplier[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt    = rem_sh[WIDTH-1:0];
        mplier_nxt = {mplier[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    result = acc_nxt;
    if (op_q == OP_DIVU) result = mplier_nxt;
  end

  assign last = (cnt == SHAMT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      op_q   <= op;
      acc    <= '0;
      cnt    <= '0;
      mcand  <= (op == OP_MUL) ? a : b;
      mplier <= (op == OP_MUL) ? b : a;
    end else if (step) begin
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with single-cycle ops and WIDTH-cycle MUL/DIVU/REMU behind a start/done handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CTRL_W-1:0] control,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  out,
  output logic              zero
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  alu_state_e         state_q;
  logic [WIDTH-1:0]   sc_res;
  logic [WIDTH-1:0]   iter_res;
  logic [SHAMT_W-1:0] shamt;
  logic               iter_req;
  logic               iter_last;
  logic               load;
  logic               step;

  // Codes beyond the low opcode bits are never iterative; they fall to the single-cycle default.
  assign iter_req = ((control >> OP_W) == '0) && is_iterative(control[OP_W-1:0]);
  assign shamt    = b[SHAMT_W-1:0];

  always_comb begin
    sc_res = '0;
    case (control)
      CTRL_W'(OP_ADD):  sc_res = a + b;
      CTRL_W'(OP_SUB):  sc_res = a - b;
      CTRL_W'(OP_AND):  sc_res = a & b;
      CTRL_W'(OP_OR):   sc_res = a | b;
      CTRL_W'(OP_XOR):  sc_res = a ^ b;
      CTRL_W'(OP_SLT):  sc_res = WIDTH'($signed(a) < $signed(b));
      CTRL_W'(OP_SLTU): sc_res = WIDTH'(a < b);
      CTRL_W'(OP_SLL):  sc_res = a << shamt;
      CTRL_W'(OP_SRL):  sc_res = a >> shamt;
      CTRL_W'(OP_SRA):  sc_res = $unsigned($signed(a) >>> shamt);
      default:          sc_res = '0;
    endcase
  end

  assign load = (state_q == IDLE) && start && iter_req;
  assign step = (state_q == CALC);

  alu_iter_unit #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .op     (control[OP_W-1:0]),
    .a      (a),
    .b      (b),
    .last   (iter_last),
    .result (iter_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out     <= '0;
      zero    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (iter_req) begin
              state_q <= CALC;
            end else begin
              out     <= sc_res;
              zero    <= (sc_res == '0);
              state_q <= DONE;
            end
          end
        end
        CALC: begin
          if (iter_last) begin
            out     <= iter_res;
            zero    <= (iter_res == '0);
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus randomized ops against an arithmetic model.
module tb_alu_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   control;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic         zero;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] held = '0;

  alu_seq #(
    .WIDTH (W),
    .CTRL_W(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .control(control),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_iter(input logic [3:0] c);
    return (c == 4'd10) || (c == 4'd11) || (c == 4'd12);
  endfunction

  function automatic logic [W-1:0] model(input logic [3:0] c, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [2*W-1:0] p;
    int unsigned sh;
    sh = y % W;
    case (c)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x & y;
      4'd3:  return x | y;
      4'd4:  return x ^ y;
      4'd5:  return (x[W-1] != y[W-1]) ? W'(x[W-1]) : W'(x < y);
      4'd6:  return W'(x < y);
      4'd7:  return x << sh;
      4'd8:  return x >> sh;
      4'd9:  return (x >> sh) | (x[W-1] ? ~({W{1'b1}} >> sh) : '0);
      4'd10: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        return p[W-1:0];
      end
      4'd11: return (y == 0) ? '1 : x / y;
      4'd12: return (y == 0) ? x : x % y;
      default: return '0;
    endcase
  endfunction

  // Issues one op from IDLE (or from DONE when start is held) and checks latency and result.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit hold, input int pulse_at);
    int n;
    int lat;
    logic [W-1:0] exp;
    exp = model(c, x, y);
    lat = is_iter(c) ? W + 1 : 1;
    control = c;
    a = x;
    b = y;
    start = 1'b1;
    if (busy) begin
      tick();
      check({tag, " gap_busy"}, W'(busy), '0);
      check({tag, " gap_done"}, W'(done), '0);
      check({tag, " gap_out"}, out, held);
    end
    n = 0;
    do begin
      tick();
      n++;
      if (!hold) begin
        start = (n == pulse_at);
        control = 4'($urandom);
      end
      a = $urandom;
      b = $urandom;
      if (!done && n < 2 * W + 8) check({tag, " hold_out"}, out, held);
    end while (!done && n < 2 * W + 8);
    check({tag, " latency"}, W'(n), W'(lat));
    check({tag, " out"}, out, exp);
    check({tag, " zero"}, W'(zero), W'(exp == '0));
    check({tag, " busy"}, W'(busy), W'(1));
    held = exp;
    if (!hold) begin
      start = 1'b0;
      tick();
      check({tag, " post_done"}, W'(done), '0);
      check({tag, " post_busy"}, W'(busy), '0);
      check({tag, " post_out"}, out, held);
    end
  endtask

  initial begin
    int seen;
    logic [3:0]   rc;
    logic [W-1:0] rx, ry;

    rst_n = 1'b0;
    start = 1'b1;
    control = 4'd0;
    a = 32'd5;
    b = 32'd7;
    repeat (3) begin
      tick();
      check("rst_busy", W'(busy), '0);
      check("rst_done", W'(done), '0);
      check("rst_out", out, '0);
      check("rst_zero", W'(zero), '0);
    end
    rst_n = 1'b1;
    run_op("add", 4'd0, 32'd5, 32'd7, 1'b0, 0);
    check("add_const", out, 32'd12);

    run_op("sub", 4'd1, 32'd9, 32'd9, 1'b0, 0);
    check("sub_zero_const", W'(zero), W'(1));
    run_op("slt", 4'd5, 32'h8000_0000, 32'd1, 1'b0, 0);
    check("slt_const", out, 32'd1);
    run_op("sltu", 4'd6, 32'h8000_0000, 32'd1, 1'b0, 0);
    check("sltu_const", out, 32'd0);
    run_op("sra", 4'd9, 32'hF000_0000, 32'd4, 1'b0, 0);
    check("sra_const", out, 32'hFF00_0000);
    run_op("sll", 4'd7, 32'h1234_5678, 32'h21, 1'b0, 0);
    check("sll_const", out, 32'h2468_ACF0);
    run_op("bad_op", 4'd14, 32'h1234_5678, 32'h1, 1'b0, 0);

    run_op("mul", 4'd10, 32'hFFFF_FFFF, 32'd3, 1'b0, 10);
    check("mul_const", out, 32'hFFFF_FFFD);
    seen = 0;
    repeat (40) begin
      tick();
      if (done) seen++;
    end
    check("mul_no_extra_done", W'(seen), '0);

    run_op("divu", 4'd11, 32'd100, 32'd7, 1'b0, 0);
    check("divu_const", out, 32'd14);
    run_op("remu", 4'd12, 32'd100, 32'd7, 1'b0, 0);
    check("remu_const", out, 32'd2);
    run_op("divu0", 4'd11, 32'd5, 32'd0, 1'b0, 0);
    check("divu0_const", out, 32'hFFFF_FFFF);
    run_op("remu0", 4'd12, 32'd5, 32'd0, 1'b0, 0);
    check("remu0_const", out, 32'd5);

    control = 4'd11;
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", W'(busy), '0);
    check("abort_done", W'(done), '0);
    check("abort_out", out, '0);
    check("abort_zero", W'(zero), '0);
    held = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (W + 5) begin
      tick();
      if (done) seen++;
    end
    check("abort_no_done", W'(seen), '0);
    run_op("add_after_abort", 4'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      rc = (i % 2 == 1) ? 4'd10 : 4'd0;
      rx = $urandom;
      ry = $urandom;
      run_op("b2b", rc, rx, ry, 1'b1, 0);
    end
    start = 1'b0;
    tick();
    check("b2b_end_busy", W'(busy), '0);
    check("b2b_end_out", out, held);

    for (int i = 0; i < 30; i++) begin
      rc = 4'($urandom_range(0, 15));
      rx = $urandom;
      ry = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 9)) : W'($urandom);
      run_op("rand", rc, rx, ry, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the processor's combinational ALU, for the multi-cycle datapath.
- Keeps the existing 3-bit operation codes. Adds XOR, SLTU and shifts as single-cycle operations.
- Adds MUL, DIVU and REMU as iterative operations that take WIDTH cycles, with a start/done handshake.
- The control FSM asserts start in an execute state and waits for done before writeback.

Parameters:
- WIDTH, 32, operand and result width in bits; must be at least 4. SHAMT_W = $clog2(WIDTH) is derived.
- CTRL_W, 4, width of the operation code.

Ports:
- clk  in  1  system clock; all flops are rising-edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  operation request; sampled only in IDLE.
- control  in  CTRL_W  operation code, sampled with start.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- busy  out  1  high while in CALC or DONE.
- done  out  1  one-cycle pulse; out and zero are valid during it.
- out  out  WIDTH  registered result.
- zero  out  1  registered flag; equals (out == 0).

Behaviour:
- Reset: state = IDLE; busy, done, zero, out and all internal registers = 0. Reset applies at any time; an operation in progress is aborted and no done is produced.
- Operation codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 SLT (signed): the existing encodings, zero-extended.
  - 0100 XOR, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA.
  - 1010 MUL (low WIDTH bits of the product), 1011 DIVU, 1100 REMU.
  - Any other code: result = 0, handled on the single-cycle path.
- Shifts use b[SHAMT_W-1:0] only.
- SLT and SLTU: out = {0…, flag}. SLT must use a true signed compare, so it stays correct when a - b overflows.
- ADD and SUB wrap modulo 2^WIDTH.
- State IDLE:
  - start=1 with a single-cycle code: compute from the live a, b and control and register the result. Go to DONE. Latency 1: done is seen the cycle after start.
  - start=1 with MUL/DIVU/REMU: latch a, b and control, clear the accumulator and the counter, go to CALC.
- State CALC: one iteration per cycle for exactly WIDTH cycles. The counter runs 0..WIDTH-1; on WIDTH-1 the result is written and the state goes to DONE.
  - MUL: shift-add. If the multiplier LSB is 1, add the multiplicand to the accumulator; then shift the multiplicand left and the multiplier right.
  - DIVU/REMU: restoring division, one quotient bit per cycle, MSB first, with a WIDTH+1-bit partial remainder.
- Divide by zero (b == 0): DIVU gives all ones, REMU gives a, matching the RISC-V spec. The same WIDTH-cycle latency still applies; there is no early exit.
- State DONE: done = 1 for exactly one cycle, then back to IDLE. out and zero are valid during done.
- Total latency: iterative ops raise done WIDTH+1 cycles after the start cycle. The start cycle is cycle 0, so done is at cycle WIDTH+1.
- Output hold: out and zero keep their value after done until the next DONE. busy is 0 in the same cycle done returns to 0.
- start while busy=1 is ignored, with no queuing. start on the same cycle the state returns to IDLE is accepted on that cycle.
- Changes to a, b or control after start are ignored for iterative ops.

Decomposition:
- Package alu_pkg:
  - Enum alu_op_e (CTRL_W bits) with the codes above.
  - Enum alu_state_e {IDLE, CALC, DONE}.
  - Function is_iterative(op).
- Sub-module alu_iter_unit: the shift-add/restoring MUL/DIV datapath with counter, driven by load and step, reporting last.
- The top level holds the FSM, the single-cycle combinational path, the result mux and the zero flag.

Test Plan (WIDTH=32):
- Reset with start held high: busy, done, out and zero stay 0 while rst_n=0. After release, ADD a=5, b=7 gives done one cycle later with out=12, zero=0.
- Single-cycle ops:
  - SUB 9-9 gives out=0, zero=1.
  - SLT a=0x80000000, b=1 gives out=1; SLTU on the same operands gives out=0.
  - SRA 0xF0000000 by 4 gives 0xFF000000.
  - SLL using b=0x21 gives a shift of 1.
- MUL a=0xFFFFFFFF, b=3: done exactly at cycle 33, out=0xFFFFFFFD. A start pulse at cycle 10 is ignored, so no extra done appears.
- DIVU 100/7 gives out=14; REMU 100/7 gives out=2. DIVU 5/0 gives 0xFFFFFFFF; REMU 5/0 gives 5. Each has latency 33.
- Drop rst_n at cycle 15 of a DIVU: everything clears immediately and no done follows. A new ADD after release completes normally.
- Back-to-back: start held high continuously with alternating ADD and MUL. Each done is followed by acceptance of the next op on the cycle the state returns to IDLE. out holds between dones.
